power_activity_probe: RTL



---
 rtl/power_probe_pkg.sv | 26 ++
 rtl/probe_popcount.sv | 17 +
 rtl/power_activity_probe.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/power_probe_pkg.sv
// rtl/power_probe_pkg.sv - shared types and register map for the power activity probe
package power_probe_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_MEASURE = 2'd2,
      ST_DONE    = 2'd3
   } probe_state_e;

   localparam logic [2:0] REG_STATUS  = 3'd0;
   localparam logic [2:0] REG_CYC_LO  = 3'd1;
   localparam logic [2:0] REG_CYC_HI  = 3'd2;
   localparam logic [2:0] REG_TGL_LO  = 3'd3;
   localparam logic [2:0] REG_TGL_HI  = 3'd4;
   localparam logic [2:0] REG_MAX_TGL = 3'd5;
   localparam logic [2:0] REG_ID      = 3'd6;

   localparam int STATUS_MEASURE = 0;
   localparam int STATUS_BUSY    = 1;
   localparam int STATUS_DONE    = 2;
   localparam int STATUS_SAT     = 3;

   localparam logic [31:0] DEFAULT_ID_VAL = 32'hA10E_0001;

endpackage

// File: rtl/probe_popcount.sv
// rtl/probe_popcount.sv - combinational population count of a DATA_W-bit word
module probe_popcount #(
   parameter int DATA_W = 64,
   parameter int PC_W   = $clog2(DATA_W + 1)
) (
   input  logic [DATA_W-1:0] data_i,
   output logic [PC_W-1:0]   count_o
);

   always_comb begin
      count_o = '0;
      for (int i = 0; i < DATA_W; i++) begin
         count_o = count_o + PC_W'(data_i[i]);
      end
   end

endmodule

// File: rtl/power_activity_probe.sv
// rtl/power_activity_probe.sv - windowed toggle counter on a probed bus with a req/gnt/rvalid read port
module power_activity_probe
   import power_probe_pkg::*;
#(
   parameter int          DATA_W = 64,
   parameter int          CNT_W  = 48,
   parameter logic [31:0] ID_VAL = DEFAULT_ID_VAL
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] probe_i,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic              clear_i,
   input  logic              req_i,
   input  logic [2:0]        addr_i,
   output logic              gnt_o,
   output logic              rvalid_o,
   output logic [31:0]       rdata_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int PC_W = $clog2(DATA_W + 1);
   localparam int HI_W = CNT_W - 32;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   probe_state_e      state_q, state_d;
   logic [DATA_W-1:0] prev_q;
   logic [CNT_W-1:0]  cyc_q, tgl_q, cyc_next, tgl_next;
   logic [CNT_W:0]    tgl_sum;
   logic [PC_W-1:0]   max_q, pc;
   logic              sat_q, busy_q, done_q;
   logic [HI_W-1:0]   cyc_shadow_q, tgl_shadow_q;
   logic              rvalid_q;
   logic [31:0]       rdata_q, rdata_d;
   logic              zero_cnt, load_prev, accumulate;

   probe_popcount #(.DATA_W(DATA_W), .PC_W(PC_W)) u_popcount (
      .data_i  (probe_i ^ prev_q),
      .count_o (pc)
   );

   // Saturating counters: stick at all-ones instead of wrapping.
   always_comb begin
      tgl_sum  = {1'b0, tgl_q} + {{(CNT_W + 1 - PC_W){1'b0}}, pc};
      tgl_next = tgl_sum[CNT_W] ? CNT_MAX : tgl_sum[CNT_W-1:0];
      cyc_next = (cyc_q == CNT_MAX) ? cyc_q : cyc_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_comb begin
      state_d    = state_q;
      zero_cnt   = 1'b0;
      load_prev  = 1'b0;
      accumulate = 1'b0;
      if (clear_i) begin
         state_d  = ST_IDLE;
         zero_cnt = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start_i) begin
                  state_d  = ST_ARMED;
                  zero_cnt = 1'b1;
               end
            end
            ST_ARMED: begin
               if (stop_i) begin
                  state_d = ST_DONE;
               end else begin
                  state_d   = ST_MEASURE;
                  load_prev = 1'b1;
               end
            end
            ST_MEASURE: begin
               if (stop_i) state_d = ST_DONE;
               else        accumulate = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cyc_q   <= '0;
         tgl_q   <= '0;
         max_q   <= '0;
         sat_q   <= 1'b0;
         prev_q  <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d == ST_ARMED) || (state_d == ST_MEASURE);
         done_q  <= (state_d == ST_DONE);
         if (zero_cnt) begin
            cyc_q <= '0;
            tgl_q <= '0;
            max_q <= '0;
            sat_q <= 1'b0;
         end else if (accumulate) begin
            cyc_q <= cyc_next;
            tgl_q <= tgl_next;
            if (pc > max_q) max_q <= pc;
            if ((cyc_next == CNT_MAX) || (tgl_next == CNT_MAX)) sat_q <= 1'b1;
         end
         if (clear_i)                      prev_q <= '0;
         else if (load_prev || accumulate) prev_q <= probe_i;
      end
   end

   always_comb begin
      rdata_d = '0;
      case (addr_i)
         REG_STATUS: begin
            rdata_d[STATUS_SAT]     = sat_q;
            rdata_d[STATUS_DONE]    = done_q;
            rdata_d[STATUS_BUSY]    = busy_q;
            rdata_d[STATUS_MEASURE] = (state_q == ST_MEASURE);
         end
         REG_CYC_LO:  rdata_d = cyc_q[31:0];
         REG_CYC_HI:  rdata_d = 32'(cyc_shadow_q);
         REG_TGL_LO:  rdata_d = tgl_q[31:0];
         REG_TGL_HI:  rdata_d = 32'(tgl_shadow_q);
         REG_MAX_TGL: rdata_d = 32'(max_q);
         REG_ID:      rdata_d = ID_VAL;
         default:     rdata_d = '0;
      endcase
   end

   // LO reads snapshot the upper half so a following HI read is tear-free.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rvalid_q     <= 1'b0;
         rdata_q      <= '0;
         cyc_shadow_q <= '0;
         tgl_shadow_q <= '0;
      end else begin
         rvalid_q <= req_i;
         if (req_i) rdata_q <= rdata_d;
         if (clear_i) begin
            cyc_shadow_q <= '0;
            tgl_shadow_q <= '0;
         end else if (req_i) begin
            if (addr_i == REG_CYC_LO) cyc_shadow_q <= cyc_q[CNT_W-1:32];
            if (addr_i == REG_TGL_LO) tgl_shadow_q <= tgl_q[CNT_W-1:32];
         end
      end
   end

   assign gnt_o    = req_i;
   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign busy_o   = busy_q;
   assign done_o   = done_q;

endmodule
